// File: rtl/ft_recovery_unit.sv
// Recovery responder: copies checkpoint x1..x(N-1) into the cores, reloads the PC, then pulses done (N+2 cycles from request).
// No backpressure: one register per cycle, the read pipelined one cycle ahead; dropping recovering_i aborts with an abort_o pulse.
module ft_recovery_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  recover_i,
    input  logic                  recovering_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pc_we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  recovery_done_o,
    output logic                  abort_o
);

    localparam int IW = ADDR_WIDTH + 1;
    // idx is one bit wider than an address so idx == NUM_REGS is representable
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COPY,
        S_LOAD_PC,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        rf_raddr_o      = '0;
        rf_we_o         = 1'b0;
        rf_waddr_o      = '0;
        rf_wdata_o      = '0;
        pc_we_o         = 1'b0;
        pc_o            = '0;
        busy_o          = 1'b0;
        recovery_done_o = 1'b0;
        abort_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (recover_i) begin
                    state_d = S_FETCH;
                    idx_d   = IW'(1);
                end
            end

            S_FETCH: begin
                busy_o     = 1'b1;
                rf_raddr_o = idx_q[ADDR_WIDTH-1:0];
                if (!recovering_i) begin
                    abort_o = 1'b1;
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = S_COPY;
                    idx_d   = idx_q + IW'(1);
                end
            end

            S_COPY: begin
                busy_o     = 1'b1;
                rf_raddr_o = idx_q[ADDR_WIDTH-1:0];
                if (!recovering_i) begin
                    abort_o = 1'b1;
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    // data on rf_rdata_i belongs to the address issued last cycle
                    rf_we_o    = 1'b1;
                    rf_waddr_o = idx_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                    rf_wdata_o = rf_rdata_i;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_LOAD_PC;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            S_LOAD_PC: begin
                busy_o = 1'b1;
                if (!recovering_i) begin
                    abort_o = 1'b1;
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    pc_we_o = 1'b1;
                    pc_o    = pc_i;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                recovery_done_o = 1'b1;
                state_d         = S_RELEASE;
                idx_d           = '0;
            end

            S_RELEASE: begin
                // a request level still held must not start a second recovery
                if (!recover_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ft_recovery_unit.sv
// Directed bench: three instances (N=32, N=2, N=16/AW=4) against a one-cycle-latency checkpoint model.
module tb_ft_recovery_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rec  [3];
    logic        ring [3];
    logic [31:0] pc_in;
    logic [31:0] rdata [3];

    logic [4:0]  a_raddr, a_waddr, b_raddr, b_waddr;
    logic [3:0]  c_raddr, c_waddr;
    logic [31:0] a_wdata, a_pc, b_wdata, b_pc, c_wdata, c_pc;
    logic        a_we, a_pcwe, a_busy, a_done, a_abort;
    logic        b_we, b_pcwe, b_busy, b_done, b_abort;
    logic        c_we, c_pcwe, c_busy, c_done, c_abort;

    wire [31:0] m_raddr [3];
    wire [31:0] m_waddr [3];
    wire [31:0] m_wdata [3];
    wire [31:0] m_pc    [3];
    wire        m_we    [3];
    wire        m_pcwe  [3];
    wire        m_busy  [3];
    wire        m_done  [3];
    wire        m_abort [3];

    assign m_raddr[0] = {27'd0, a_raddr};
    assign m_raddr[1] = {27'd0, b_raddr};
    assign m_raddr[2] = {28'd0, c_raddr};
    assign m_waddr[0] = {27'd0, a_waddr};
    assign m_waddr[1] = {27'd0, b_waddr};
    assign m_waddr[2] = {28'd0, c_waddr};
    assign m_wdata[0] = a_wdata;
    assign m_wdata[1] = b_wdata;
    assign m_wdata[2] = c_wdata;
    assign m_pc[0]    = a_pc;
    assign m_pc[1]    = b_pc;
    assign m_pc[2]    = c_pc;
    assign m_we[0]    = a_we;
    assign m_we[1]    = b_we;
    assign m_we[2]    = c_we;
    assign m_pcwe[0]  = a_pcwe;
    assign m_pcwe[1]  = b_pcwe;
    assign m_pcwe[2]  = c_pcwe;
    assign m_busy[0]  = a_busy;
    assign m_busy[1]  = b_busy;
    assign m_busy[2]  = c_busy;
    assign m_done[0]  = a_done;
    assign m_done[1]  = b_done;
    assign m_done[2]  = c_done;
    assign m_abort[0] = a_abort;
    assign m_abort[1] = b_abort;
    assign m_abort[2] = c_abort;

    ft_recovery_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .recover_i(rec[0]), .recovering_i(ring[0]),
        .rf_raddr_o(a_raddr), .rf_rdata_i(rdata[0]), .rf_we_o(a_we),
        .rf_waddr_o(a_waddr), .rf_wdata_o(a_wdata), .pc_i(pc_in),
        .pc_we_o(a_pcwe), .pc_o(a_pc), .busy_o(a_busy),
        .recovery_done_o(a_done), .abort_o(a_abort)
    );

    ft_recovery_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .recover_i(rec[1]), .recovering_i(ring[1]),
        .rf_raddr_o(b_raddr), .rf_rdata_i(rdata[1]), .rf_we_o(b_we),
        .rf_waddr_o(b_waddr), .rf_wdata_o(b_wdata), .pc_i(pc_in),
        .pc_we_o(b_pcwe), .pc_o(b_pc), .busy_o(b_busy),
        .recovery_done_o(b_done), .abort_o(b_abort)
    );

    ft_recovery_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(16)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .recover_i(rec[2]), .recovering_i(ring[2]),
        .rf_raddr_o(c_raddr), .rf_rdata_i(rdata[2]), .rf_we_o(c_we),
        .rf_waddr_o(c_waddr), .rf_wdata_o(c_wdata), .pc_i(pc_in),
        .pc_we_o(c_pcwe), .pc_o(c_pc), .busy_o(c_busy),
        .recovery_done_o(c_done), .abort_o(c_abort)
    );

    // checkpoint register file: x[k] = 0xA000_0000 + k, one cycle read latency
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rdata[i] <= 32'hA000_0000 + m_raddr[i];
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs_nz(input int i);
        return {m_busy[i], m_we[i], m_pcwe[i], m_done[i], m_abort[i],
                |m_raddr[i], |m_waddr[i], |m_wdata[i], |m_pc[i]};
    endfunction

    int          n_wr, ord_err, first_wr, last_wr, pc_cyc, n_pcwe;
    int          done_cyc, n_done, abort_cyc, n_abort, busy_err, zero_wr, rst_nz;
    logic [31:0] pc_val;

    // One request on instance i; cycle 1 is the first cycle after the sampling edge.
    task automatic run_seq(input int i, input int n, input int req_len,
                           input int abort_at, input int rst_at, input int ncyc);
        int   end_c;
        logic exp_busy;
        n_wr = 0; ord_err = 0; first_wr = -1; last_wr = -1; pc_cyc = 0; n_pcwe = 0;
        done_cyc = 0; n_done = 0; abort_cyc = 0; n_abort = 0; busy_err = 0;
        zero_wr = 0; rst_nz = 0; pc_val = '0;
        end_c = n + 1;
        if (abort_at > 0 && abort_at < end_c) end_c = abort_at;
        if (rst_at > 0 && rst_at < end_c) end_c = rst_at;
        @(negedge clk);
        rec[i]  = 1'b1;
        ring[i] = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == req_len) rec[i] = 1'b0;
            if (c == abort_at) ring[i] = 1'b0;
            if (c == rst_at) rst = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
            #1;
            exp_busy = (c <= end_c);
            if (m_busy[i] !== exp_busy) busy_err++;
            if (rst_at > 0 && c == rst_at + 1 && outs_nz(i) !== 9'd0) rst_nz++;
            if (m_we[i] === 1'b1) begin
                n_wr++;
                if (n_wr == 1) first_wr = int'(m_waddr[i]);
                last_wr = int'(m_waddr[i]);
                if (m_waddr[i] !== 32'(n_wr) || m_wdata[i] !== 32'hA000_0000 + 32'(n_wr)
                    || c != n_wr + 1) ord_err++;
                if (m_waddr[i] == 32'd0) zero_wr++;
            end
            if (m_pcwe[i] === 1'b1) begin
                n_pcwe++;
                pc_cyc = c;
                pc_val = m_pc[i];
            end
            if (m_done[i] === 1'b1) begin
                n_done++;
                done_cyc = c;
            end
            if (m_abort[i] === 1'b1) begin
                n_abort++;
                abort_cyc = c;
            end
        end
        rec[i]  = 1'b0;
        ring[i] = 1'b1;
        rst     = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        pc_in = 32'h0000_0180;
        for (int i = 0; i < 3; i++) begin
            rec[i]  = 1'b0;
            ring[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outs0", 32'(outs_nz(0)), 32'd0);
        check_eq("reset_outs1", 32'(outs_nz(1)), 32'd0);
        check_eq("reset_outs2", 32'(outs_nz(2)), 32'd0);
        rst = 1'b0;

        // nominal copy, request held 5 cycles
        run_seq(0, 32, 5, 0, 0, 35);
        check_eq("nom_nwr", 32'(n_wr), 32'd31);
        check_eq("nom_order", 32'(ord_err), 32'd0);
        check_eq("nom_pcwe_n", 32'(n_pcwe), 32'd1);
        check_eq("nom_pc_cyc", 32'(pc_cyc), 32'd33);
        check_eq("nom_pc_val", pc_val, 32'h0000_0180);
        check_eq("nom_done_n", 32'(n_done), 32'd1);
        check_eq("nom_done_cyc", 32'(done_cyc), 32'd34);
        check_eq("nom_busy", 32'(busy_err), 32'd0);
        check_eq("nom_abort", 32'(n_abort), 32'd0);

        // back-to-back: request raised in the first IDLE cycle after RELEASE
        run_seq(0, 32, 1, 0, 0, 40);
        check_eq("b2b_nwr", 32'(n_wr), 32'd31);
        check_eq("b2b_order", 32'(ord_err), 32'd0);
        check_eq("b2b_zero_wr", 32'(zero_wr), 32'd0);
        check_eq("b2b_done_cyc", 32'(done_cyc), 32'd34);
        check_eq("b2b_busy", 32'(busy_err), 32'd0);

        // held request: 50 cycles, must not restart
        run_seq(0, 32, 50, 0, 0, 55);
        check_eq("hold_nwr", 32'(n_wr), 32'd31);
        check_eq("hold_done_n", 32'(n_done), 32'd1);
        check_eq("hold_done_cyc", 32'(done_cyc), 32'd34);
        check_eq("hold_busy", 32'(busy_err), 32'd0);

        // abort in cycle 10
        run_seq(0, 32, 3, 10, 0, 12);
        check_eq("abt_n", 32'(n_abort), 32'd1);
        check_eq("abt_cyc", 32'(abort_cyc), 32'd10);
        check_eq("abt_nwr", 32'(n_wr), 32'd8);
        check_eq("abt_last", 32'(last_wr), 32'd8);
        check_eq("abt_pcwe", 32'(n_pcwe), 32'd0);
        check_eq("abt_done", 32'(n_done), 32'd0);
        check_eq("abt_busy", 32'(busy_err), 32'd0);
        run_seq(0, 32, 3, 0, 0, 35);
        check_eq("abt_re_first", 32'(first_wr), 32'd1);
        check_eq("abt_re_nwr", 32'(n_wr), 32'd31);
        check_eq("abt_re_done", 32'(done_cyc), 32'd34);

        // reset asserted in cycle 20
        run_seq(0, 32, 3, 0, 20, 24);
        check_eq("rst_outs", 32'(rst_nz), 32'd0);
        check_eq("rst_nwr", 32'(n_wr), 32'd19);
        check_eq("rst_done", 32'(n_done), 32'd0);
        check_eq("rst_abort", 32'(n_abort), 32'd0);
        check_eq("rst_busy", 32'(busy_err), 32'd0);
        run_seq(0, 32, 3, 0, 0, 35);
        check_eq("rst_re_nwr", 32'(n_wr), 32'd31);
        check_eq("rst_re_order", 32'(ord_err), 32'd0);
        check_eq("rst_re_done", 32'(done_cyc), 32'd34);

        // NUM_REGS=2
        run_seq(1, 2, 3, 0, 0, 8);
        check_eq("n2_nwr", 32'(n_wr), 32'd1);
        check_eq("n2_first", 32'(first_wr), 32'd1);
        check_eq("n2_pc_cyc", 32'(pc_cyc), 32'd3);
        check_eq("n2_done_cyc", 32'(done_cyc), 32'd4);
        check_eq("n2_busy", 32'(busy_err), 32'd0);

        // NUM_REGS=16, ADDR_WIDTH=4
        run_seq(2, 16, 3, 0, 0, 22);
        check_eq("n16_nwr", 32'(n_wr), 32'd15);
        check_eq("n16_last", 32'(last_wr), 32'd15);
        check_eq("n16_order", 32'(ord_err), 32'd0);
        check_eq("n16_zero_wr", 32'(zero_wr), 32'd0);
        check_eq("n16_done_cyc", 32'(done_cyc), 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft_recovery_unit.md
# ft_recovery_unit

Responder side of the fault-tolerance recovery handshake. The FT controller raises `recover_i` after resetting the lockstep cores and then waits for `recovery_done_o`. This block restores architectural state into both cores in that window. It copies registers x1..x(NUM_REGS-1) from the checkpoint register-file read port to the cores' register-file write port, then reloads the checkpoint PC, then pulses `recovery_done_o` back to the controller.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: register and PC width.
- `ADDR_WIDTH`, default 5: register address width.
- `NUM_REGS`, default 32: register count including x0. Legal range is 2..2^ADDR_WIDTH.

Ports:
- `clk_i`, in, 1: clock. Everything is sampled on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `recover_i`, in, 1: recovery request level from the FT controller.
- `recovering_i`, in, 1: level from the controller, high for the whole recovery window. If it drops while the block is busy, the block aborts.
- `rf_raddr_o`, out, ADDR_WIDTH: checkpoint register-file read address.
- `rf_rdata_i`, in, DATA_WIDTH: checkpoint read data, valid exactly one cycle after its address.
- `rf_we_o`, out, 1: core register-file write enable.
- `rf_waddr_o`, out, ADDR_WIDTH: core register-file write address.
- `rf_wdata_o`, out, DATA_WIDTH: core register-file write data.
- `pc_i`, in, DATA_WIDTH: checkpoint PC.
- `pc_we_o`, out, 1: PC load strobe to the cores.
- `pc_o`, out, DATA_WIDTH: PC value to load.
- `busy_o`, out, 1: high in FETCH, COPY and LOAD_PC.
- `recovery_done_o`, out, 1: one-cycle completion pulse.
- `abort_o`, out, 1: one-cycle pulse on an aborted recovery.

## Operation

States: IDLE, FETCH, COPY, LOAD_PC, DONE, RELEASE.

Transitions:
- IDLE: `recover_i`=1 → FETCH. The register counter `idx` is set to 1.
- FETCH: `rf_raddr_o`=`idx` (=1). Next state is COPY, with `idx` incremented.
- COPY: `rf_we_o`=1, `rf_waddr_o`=`idx`-1, `rf_wdata_o`=`rf_rdata_i`. In the same cycle `rf_raddr_o`=`idx`, which pipelines the next read.
  - When `idx`-1 = NUM_REGS-1, the next state is LOAD_PC. `rf_raddr_o` is don't-care on that last cycle.
  - Otherwise `idx` is incremented.
- LOAD_PC: `pc_we_o`=1, `pc_o`=`pc_i`. Next state is DONE.
- DONE: `recovery_done_o`=1. Next state is RELEASE.
- RELEASE: wait for `recover_i`=0, then go to IDLE. This prevents a second recovery from a request level still held by the controller.

Abort:
- In FETCH, COPY or LOAD_PC, if `recovering_i`=0, go to IDLE.
- `abort_o`=1 for one cycle.
- No write occurs in the aborting cycle.
- `recovery_done_o` is not pulsed.

Datapath rules:
- x0 is never read or written. `rf_waddr_o` never equals 0 while `rf_we_o`=1.
- `idx` is ADDR_WIDTH+1 bits wide, so NUM_REGS=2^ADDR_WIDTH does not wrap. `rf_raddr_o`/`rf_waddr_o` are its low ADDR_WIDTH bits.

Strobe outputs:
- `rf_we_o`, `pc_we_o`, `recovery_done_o` and `abort_o` are high only in the states listed above.
- Outside those states, `rf_waddr_o`, `rf_wdata_o` and `pc_o` are driven to 0.

Reset:
- `rst_i` forces IDLE and `idx`=0.
- All outputs are 0 in the cycle after the reset edge.
- Reset wins over every other event, including mid-copy. No done or abort pulse follows a reset.

## Timing

Cycle numbering:
- C0 is the edge where IDLE samples `recover_i`=1.
- Cycle k is the interval after edge Ck.

Schedule (with N = NUM_REGS):

| Cycle(s) | State | Activity |
|---|---|---|
| 1 | FETCH | `rf_raddr_o`=1 |
| 2..N | COPY | writes x1..x(N-1); write of x(k-1) in cycle k |
| N+1 | LOAD_PC | PC load |
| N+2 | DONE | `recovery_done_o`=1 |

Latency and handshake:
- With default N=32, `recovery_done_o` is high in cycle 34, and the block returns to IDLE no earlier than cycle 36.
- `recovery_done_o` and `abort_o` are high for exactly one full clock period. That is sufficient for a controller that samples on the falling edge.
- `recover_i` pulses that arrive while the block is busy are ignored.
- A `recover_i` level still high in RELEASE holds the block in RELEASE.
- If `recovering_i`=0 and the copy completes on the same edge, the abort takes priority.

## Test plan

1. **Nominal copy.** Preload the checkpoint model with x[k]=0xA000_0000+k and `pc_i`=0x0000_0180, then pulse `recover_i` for 5 cycles. Required:
   - exactly 31 writes, addresses 1..31 in order, data 0xA000_0001..0xA000_001F;
   - `pc_we_o` in cycle 33 with `pc_o`=0x180;
   - `recovery_done_o` in cycle 34 only, and `busy_o` high in cycles 1..33.
2. **Held request.** Keep `recover_i`=1 for 50 cycles. Required: one recovery, one done pulse, the block stays in RELEASE until `recover_i` falls, then returns to IDLE; no second copy.
3. **Abort.** Drop `recovering_i` in cycle 10. Required: `abort_o`=1 for one cycle, last write is x8, no `pc_we_o`, no done pulse, the next request restarts at x1.
4. **Reset mid-operation.** Assert `rst_i` in cycle 20. Required: all outputs 0 on the next cycle, no done or abort pulse, clean restart on the following request.
5. **Parameter corner.** Run with NUM_REGS=2, then with NUM_REGS=16 and ADDR_WIDTH=4. Required:
   - NUM_REGS=2: one write (x1), done in cycle 4;
   - NUM_REGS=16: writes x1..x15 with no wrap, done in cycle 18.
6. **Back-to-back.** Issue a second request 1 cycle after RELEASE exits. Required: an identical second sequence with `rf_waddr_o` never 0 while `rf_we_o`=1.
